// File: rtl/reg_file_sb.sv
// Parametrised register file with per-register busy scoreboard and busy counter.
// Optional write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_PORTS    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] AD_R,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    RD,
  output logic [READ_PORTS-1:0]               BUSY_R,
  input  logic [ADDRESS_WIDTH-1:0]            AD3,
  input  logic [DATA_WIDTH-1:0]               WD3,
  input  logic                                WE3,
  input  logic                                RSV_EN,
  input  logic [ADDRESS_WIDTH-1:0]            RSV_AD,
  output logic [ADDRESS_WIDTH:0]              BUSY_CNT
);

  localparam int NREG = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    r_regs [NREG];
  logic [NREG-1:0]          r_busy;
  logic [ADDRESS_WIDTH:0]   r_busy_cnt;

  logic                     w_wr;
  logic                     w_rsv;
  logic [NREG-1:0]          w_busy_nxt;
  logic [ADDRESS_WIDTH:0]   w_cnt_nxt;
  logic [ADDRESS_WIDTH-1:0] w_ad [READ_PORTS];

  always_comb begin
    w_wr  = WE3 && (AD3 != '0);
    w_rsv = RSV_EN && (RSV_AD != '0);
  end

  // Reserve is applied after release so a same-cycle reissue stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr)
      w_busy_nxt[AD3] = 1'b0;
    if (w_rsv)
      w_busy_nxt[RSV_AD] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      w_cnt_nxt = w_cnt_nxt
                + {{ADDRESS_WIDTH{1'b0}}, w_busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr)
        r_regs[AD3] <= WD3;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    RD     = '0;
    BUSY_R = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      w_ad[i] = AD_R[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      RD[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ad[i]];
      BUSY_R[i] = r_busy[w_ad[i]];
`ifdef REG_FILE_BYPASS_EN
      if (w_wr && (w_ad[i] == AD3)) begin
        RD[i*DATA_WIDTH +: DATA_WIDTH] = WD3;
        BUSY_R[i] = 1'b0;
      end
`endif
    end
  end

  assign BUSY_CNT = r_busy_cnt;

endmodule
